tlb_l1: RTL and testbench

- Fully associative, single-outstanding translation lookaside buffer. Sits directly upstream of the page-table walker (ptw).
- Accepts virtual-address lookups from the core side. Returns the physical address on a hit.
- On a miss, issues one walk on the ptw request/response handshake, fills an entry from the returned PTE, then responds.
- PTE format: valid = pte[0], R = pte[1], W = pte[2], X = pte[3], PPN = pte[31:12].
- Translation rule: paddr = {PPN, vaddr[11:0]}.

---
 rtl/tlb_l1.sv | 212 +++++++++++++++++++++
 tb/tb_tlb_l1.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_l1.sv
// tlb_l1: fully associative, single-outstanding TLB placed in front of a page-table walker.
// Optional macro TLB_STATS_EN adds saturating hit/miss counters on hit_cnt_o / miss_cnt_o.
module tlb_l1 #(
   parameter int ENTRIES = 8,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tlb_req_valid_i,
   output logic        tlb_req_ready_o,
   input  logic [31:0] tlb_vaddr_i,
   input  logic        tlb_write_i,
   output logic        tlb_resp_valid_o,
   input  logic        tlb_resp_ready_i,
   output logic [31:0] tlb_paddr_o,
   output logic        tlb_hit_o,
   output logic        tlb_fault_o,
   input  logic        tlb_flush_i,
   output logic        ptw_req_valid_o,
   input  logic        ptw_req_ready_i,
   output logic [31:0] ptw_vaddr_o,
   input  logic        ptw_resp_valid_i,
   output logic        ptw_resp_ready_o,
   input  logic [31:0] ptw_pte_i
`ifdef TLB_STATS_EN
   ,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WALK_REQ,
      S_WALK_WAIT,
      S_RESP
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        vaddr_q, vaddr_d;
   logic               write_q, write_d;
   logic [31:0]        paddr_q, paddr_d;
   logic               hit_q, hit_d;
   logic               fault_q, fault_d;
   logic [IDX_W-1:0]   victim_q, victim_d;
   logic [ENTRIES-1:0] valid_q, valid_d;

   logic [19:0]        vpn_q   [ENTRIES];
   logic [19:0]        ppn_q   [ENTRIES];
   logic [3:0]         flags_q [ENTRIES];

   logic               fill_en;
   logic [ENTRIES-1:0] hit_vec;
   logic [19:0]        hit_ppn;
   logic [3:0]         hit_flags;
   logic               unused_ok;

   // Fault when the page is not readable, or a store targets a page without W.
   function automatic logic perm_fault(input logic [3:0] flags, input logic wr);
      return !flags[1] || (wr && !flags[2]);
   endfunction

   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         hit_vec[i] = valid_q[i] && (vpn_q[i] == vaddr_q[31:12]);
      end
   end

   // At most one entry can match, so an OR-reduction acts as the mux.
   always_comb begin
      hit_ppn   = '0;
      hit_flags = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (hit_vec[i]) begin
            hit_ppn   = hit_ppn | ppn_q[i];
            hit_flags = hit_flags | flags_q[i];
         end
      end
   end

   assign unused_ok = ^{ptw_pte_i[11:4], hit_flags[3], hit_flags[0]};

   always_comb begin
      state_d  = state_q;
      vaddr_d  = vaddr_q;
      write_d  = write_q;
      paddr_d  = paddr_q;
      hit_d    = hit_q;
      fault_d  = fault_q;
      victim_d = victim_q;
      valid_d  = valid_q;
      fill_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tlb_flush_i) begin
               valid_d  = '0;
               victim_d = '0;
            end else if (tlb_req_valid_i) begin
               vaddr_d = tlb_vaddr_i;
               write_d = tlb_write_i;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (|hit_vec) begin
               hit_d   = 1'b1;
               fault_d = perm_fault(hit_flags, write_q);
               paddr_d = perm_fault(hit_flags, write_q) ? 32'h0 : {hit_ppn, vaddr_q[11:0]};
               state_d = S_RESP;
            end else begin
               state_d = S_WALK_REQ;
            end
         end
         S_WALK_REQ: begin
            if (ptw_req_ready_i) state_d = S_WALK_WAIT;
         end
         S_WALK_WAIT: begin
            if (ptw_resp_valid_i) begin
               hit_d   = 1'b0;
               state_d = S_RESP;
               if (ptw_pte_i[0]) begin
                  fill_en           = 1'b1;
                  valid_d[victim_q] = 1'b1;
                  victim_d          = victim_q + 1'b1;
                  fault_d           = perm_fault(ptw_pte_i[3:0], write_q);
                  paddr_d           = perm_fault(ptw_pte_i[3:0], write_q) ? 32'h0
                                      : {ptw_pte_i[31:12], vaddr_q[11:0]};
               end else begin
                  fault_d = 1'b1;
                  paddr_d = 32'h0;
               end
            end
         end
         S_RESP: begin
            if (tlb_resp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         vaddr_q  <= '0;
         write_q  <= 1'b0;
         paddr_q  <= '0;
         hit_q    <= 1'b0;
         fault_q  <= 1'b0;
         victim_q <= '0;
         valid_q  <= '0;
      end else begin
         state_q  <= state_d;
         vaddr_q  <= vaddr_d;
         write_q  <= write_d;
         paddr_q  <= paddr_d;
         hit_q    <= hit_d;
         fault_q  <= fault_d;
         victim_q <= victim_d;
         valid_q  <= valid_d;
      end
   end

   // Entry payload needs no reset: valid_q gates every use of it.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         vpn_q[victim_q]   <= vaddr_q[31:12];
         ppn_q[victim_q]   <= ptw_pte_i[31:12];
         flags_q[victim_q] <= ptw_pte_i[3:0];
      end
   end

   assign tlb_req_ready_o  = (state_q == S_IDLE) && !tlb_flush_i;
   assign tlb_resp_valid_o = (state_q == S_RESP);
   assign tlb_paddr_o      = paddr_q;
   assign tlb_hit_o        = hit_q;
   assign tlb_fault_o      = fault_q;
   assign ptw_req_valid_o  = (state_q == S_WALK_REQ);
   assign ptw_vaddr_o      = vaddr_q;
   assign ptw_resp_ready_o = (state_q == S_WALK_WAIT);

`ifdef TLB_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;
   logic        lookup_hit, lookup_miss;

   assign lookup_hit  = (state_q == S_LOOKUP) && (|hit_vec);
   assign lookup_miss = (state_q == S_LOOKUP) && !(|hit_vec);

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (lookup_hit && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_d  = hit_cnt_q + 32'd1;
      if (lookup_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_l1.sv
// Scoreboard bench for tlb_l1: expected responses queued at request time, checked on output.
module tb_tlb_l1;

   logic        clk = 1'b0;
   logic        rst;
   logic        tlb_req_valid_i;
   logic        tlb_req_ready_o;
   logic [31:0] tlb_vaddr_i;
   logic        tlb_write_i;
   logic        tlb_resp_valid_o;
   logic        tlb_resp_ready_i;
   logic [31:0] tlb_paddr_o;
   logic        tlb_hit_o;
   logic        tlb_fault_o;
   logic        tlb_flush_i;
   logic        ptw_req_valid_o;
   logic        ptw_req_ready_i;
   logic [31:0] ptw_vaddr_o;
   logic        ptw_resp_valid_i;
   logic        ptw_resp_ready_o;
   logic [31:0] ptw_pte_i;
`ifdef TLB_STATS_EN
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;
`endif

   always #5 clk = ~clk;

   tlb_l1 #(.ENTRIES(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .tlb_req_valid_i  (tlb_req_valid_i),
      .tlb_req_ready_o  (tlb_req_ready_o),
      .tlb_vaddr_i      (tlb_vaddr_i),
      .tlb_write_i      (tlb_write_i),
      .tlb_resp_valid_o (tlb_resp_valid_o),
      .tlb_resp_ready_i (tlb_resp_ready_i),
      .tlb_paddr_o      (tlb_paddr_o),
      .tlb_hit_o        (tlb_hit_o),
      .tlb_fault_o      (tlb_fault_o),
      .tlb_flush_i      (tlb_flush_i),
      .ptw_req_valid_o  (ptw_req_valid_o),
      .ptw_req_ready_i  (ptw_req_ready_i),
      .ptw_vaddr_o      (ptw_vaddr_o),
      .ptw_resp_valid_i (ptw_resp_valid_i),
      .ptw_resp_ready_o (ptw_resp_ready_o),
      .ptw_pte_i        (ptw_pte_i)
`ifdef TLB_STATS_EN
      ,
      .hit_cnt_o        (hit_cnt_o),
      .miss_cnt_o       (miss_cnt_o)
`endif
   );

   typedef struct {
      logic [31:0] paddr;
      logic        hit;
      logic        fault;
   } resp_t;

   typedef struct {
      logic [31:0] vaddr;
      logic [31:0] pte;
   } walk_t;

   resp_t sb_q[$];
   walk_t walk_q[$];
   int    n_chk = 0;
   int    n_fail = 0;
   int    walk_cnt = 0;
   int    exp_hits = 0;
   int    exp_misses = 0;
   bit    ptw_auto = 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Walker model: serves queued PTEs; an unplanned walk gets an invalid PTE.
   initial begin
      walk_t w;
      ptw_req_ready_i  = 1'b0;
      ptw_resp_valid_i = 1'b0;
      ptw_pte_i        = '0;
      forever begin
         @(negedge clk);
         if (ptw_auto && rst && ptw_req_valid_o) begin
            walk_cnt++;
            chk("walk_expected", walk_q.size() != 0, 1);
            if (walk_q.size() != 0) w = walk_q.pop_front();
            else w = '{ptw_vaddr_o, 32'h0};
            chk("ptw_vaddr", ptw_vaddr_o, w.vaddr);
            ptw_req_ready_i = 1'b1;
            @(negedge clk);
            ptw_req_ready_i  = 1'b0;
            ptw_resp_valid_i = 1'b1;
            ptw_pte_i        = w.pte;
            @(negedge clk);
            ptw_resp_valid_i = 1'b0;
            ptw_pte_i        = '0;
         end
      end
   end

   // Response monitor: every accepted response is checked against the scoreboard.
   initial begin
      resp_t r;
      forever begin
         @(negedge clk);
         if (rst && tlb_resp_valid_o && tlb_resp_ready_i) begin
            chk("resp_expected", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
               r = sb_q.pop_front();
               chk("paddr", tlb_paddr_o, r.paddr);
               chk("hit", tlb_hit_o, r.hit);
               chk("fault", tlb_fault_o, r.fault);
            end
         end
      end
   end

   task automatic xlate(input logic [31:0] va, input logic wr, input logic [31:0] pte,
                        input bit walk, input logic [31:0] ep, input logic eh,
                        input logic ef, input bit fl);
      int n;
      int w0;
      if (walk) begin
         walk_q.push_back('{va, pte});
         exp_misses++;
      end else begin
         exp_hits++;
      end
      sb_q.push_back('{ep, eh, ef});
      w0 = walk_cnt;
      @(negedge clk);
      tlb_req_valid_i = 1'b1;
      tlb_vaddr_i     = va;
      tlb_write_i     = wr;
      n = 0;
      while (!tlb_req_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_accept", tlb_req_ready_o, 1);
      @(negedge clk);
      tlb_req_valid_i = 1'b0;
      if (fl) tlb_flush_i = 1'b1;
      n = 1;
      while (!tlb_resp_valid_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      tlb_flush_i = 1'b0;
      chk("latency", n, walk ? 4 : 2);
      chk("walks", walk_cnt - w0, walk ? 1 : 0);
   endtask

   task automatic do_flush();
      @(negedge clk);
      tlb_flush_i = 1'b1;
      tlb_req_valid_i = 1'b1;
      #1;
      chk("flush_ready_low", tlb_req_ready_o, 0);
      @(negedge clk);
      tlb_flush_i = 1'b0;
      tlb_req_valid_i = 1'b0;
      #1;
      chk("flush_ready_back", tlb_req_ready_o, 1);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_req_ready"}, tlb_req_ready_o, 1);
      chk({tag, "_resp_valid"}, tlb_resp_valid_o, 0);
      chk({tag, "_ptw_req_valid"}, ptw_req_valid_o, 0);
      chk({tag, "_ptw_resp_ready"}, ptw_resp_ready_o, 0);
      chk({tag, "_paddr"}, tlb_paddr_o, 0);
      chk({tag, "_hit"}, tlb_hit_o, 0);
      chk({tag, "_fault"}, tlb_fault_o, 0);
   endtask

   task automatic chk_stats();
`ifdef TLB_STATS_EN
      chk("hit_cnt", hit_cnt_o, exp_hits);
      chk("miss_cnt", miss_cnt_o, exp_misses);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [31:0] va;
      logic [31:0] pte;
      rst              = 1'b0;
      tlb_req_valid_i  = 1'b0;
      tlb_vaddr_i      = '0;
      tlb_write_i      = 1'b0;
      tlb_resp_ready_i = 1'b1;
      tlb_flush_i      = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      chk("reset_ptw_vaddr", ptw_vaddr_o, 0);
      chk_stats();
      rst = 1'b1;

      // Cold miss, then hit in the same page.
      xlate(32'h0000_0000, 1'b0, 32'h1000_000F, 1, 32'h1000_0000, 1'b0, 1'b0, 0);
      xlate(32'h0000_0800, 1'b0, 32'h0,         0, 32'h1000_0800, 1'b1, 1'b0, 0);
      // Invalid PTE: fault, no fill, so a repeat walks again.
      xlate(32'h0040_0000, 1'b0, 32'h1234_0000, 1, 32'h0, 1'b0, 1'b1, 0);
      xlate(32'h0040_0000, 1'b0, 32'h1234_0000, 1, 32'h0, 1'b0, 1'b1, 0);
      // Read-only page: store faults but the entry is filled.
      xlate(32'h0000_2000, 1'b1, 32'h1200_0003, 1, 32'h0,         1'b0, 1'b1, 0);
      xlate(32'h0000_2004, 1'b0, 32'h0,         0, 32'h1200_0004, 1'b1, 1'b0, 0);
      xlate(32'h0000_2008, 1'b1, 32'h0,         0, 32'h0,         1'b1, 1'b1, 0);
      // Execute-only page: reads fault on fill and on hit.
      xlate(32'h0000_5000, 1'b0, 32'h3300_0009, 1, 32'h0, 1'b0, 1'b1, 0);
      xlate(32'h0000_5010, 1'b0, 32'h0,         0, 32'h0, 1'b1, 1'b1, 0);
      chk_stats();

      // Flush, then 9 fills into 8 entries; the 9th evicts page 0.
      do_flush();
      for (int i = 0; i < 9; i++) begin
         va  = i << 12;
         pte = {20'hA0000 + 20'(i), 12'h00F};
         xlate(va, 1'b0, pte, 1, {pte[31:12], 12'h000}, 1'b0, 1'b0, 0);
      end
      xlate(32'h0000_8010, 1'b1, 32'h0,         0, 32'hA000_8010, 1'b1, 1'b0, 0);
      xlate(32'h0000_0000, 1'b0, 32'hB000_0007, 1, 32'hB000_0000, 1'b0, 1'b0, 0);
      xlate(32'h0000_2abc, 1'b0, 32'h0,         0, 32'hA000_2abc, 1'b1, 1'b0, 0);
      // Flush held during a translation is ignored.
      xlate(32'h0000_3000, 1'b0, 32'h0,         0, 32'hA000_3000, 1'b1, 1'b0, 1);
      xlate(32'h0000_4000, 1'b0, 32'h0,         0, 32'hA000_4000, 1'b1, 1'b0, 0);
      chk_stats();
      do_flush();
      xlate(32'h0000_2000, 1'b0, 32'hC000_0003, 1, 32'hC000_0000, 1'b0, 1'b0, 0);
      xlate(32'h0000_8000, 1'b0, 32'hC100_0003, 1, 32'hC100_0000, 1'b0, 1'b0, 0);
      chk_stats();

      // Reset mid-walk with walker backpressure.
      ptw_auto = 1'b0;
      @(negedge clk);
      tlb_req_valid_i = 1'b1;
      tlb_vaddr_i     = 32'h0000_9000;
      tlb_write_i     = 1'b0;
      chk("rst_test_accept", tlb_req_ready_o, 1);
      @(negedge clk);
      tlb_req_valid_i = 1'b0;
      n = 0;
      while (!ptw_req_valid_o && n < 10) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         chk("bp_req_valid", ptw_req_valid_o, 1);
         chk("bp_vaddr", ptw_vaddr_o, 32'h0000_9000);
         @(negedge clk);
      end
      ptw_req_ready_i = 1'b1;
      @(negedge clk);
      ptw_req_ready_i = 1'b0;
      chk("walk_wait_ready", ptw_resp_ready_o, 1);
      ptw_resp_valid_i = 1'b1;
      ptw_pte_i        = 32'h7700_000F;
      rst              = 1'b0;
      #1;
      chk("midwalk_rst_req_ready", tlb_req_ready_o, 1);
      chk("midwalk_rst_ptw_req", ptw_req_valid_o, 0);
      chk("midwalk_rst_ptw_resp_ready", ptw_resp_ready_o, 0);
      chk("midwalk_rst_resp_valid", tlb_resp_valid_o, 0);
      repeat (2) @(negedge clk);
      ptw_resp_valid_i = 1'b0;
      ptw_pte_i        = '0;
      rst              = 1'b1;
      exp_hits         = 0;
      exp_misses       = 0;
      chk_stats();
      ptw_auto = 1'b1;
      xlate(32'h0000_9000, 1'b0, 32'h5555_500F, 1, 32'h5555_5000, 1'b0, 1'b0, 0);
      xlate(32'h0000_8000, 1'b0, 32'h6666_6003, 1, 32'h6666_6000, 1'b0, 1'b0, 0);
      xlate(32'h0000_9004, 1'b0, 32'h0,         0, 32'h5555_5004, 1'b1, 1'b0, 0);
      chk_stats();

      repeat (2) @(negedge clk);
      chk("sb_drained", sb_q.size(), 0);
      chk("walks_drained", walk_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
